// File: rtl/alu_issue_stage.sv
// RV32I ID/EX issue stage: decodes instr + regfile data into ALU ctrl/operands, 1-cycle registered valid/ready stage.
// Optional ALU_ISSUE_SKID_EN adds a one-entry skid buffer so in_ready comes straight from a flop.
module alu_issue_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_CNT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_data0,
  output logic [XLEN-1:0] alu_data1,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal,
  output logic [XLEN-1:0] issue_cnt
);

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic [4:0]      rd;
    logic            rw;
    logic            br;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } entry_t;

  entry_t          dec, out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] issue_cnt_q, issue_cnt_d;
  logic            out_free;
  logic            wr, ill;
  logic [3:0]      op_fn;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    op_fn = 4'b0000;
    case (funct3)
      3'b000: op_fn = 4'b0000;
      3'b001: op_fn = 4'b0010;
      3'b010: op_fn = 4'b1110;
      3'b011: op_fn = 4'b1111;
      3'b100: op_fn = 4'b0011;
      3'b101: op_fn = 4'b0100;
      3'b110: op_fn = 4'b0110;
      default: op_fn = 4'b0111;
    endcase
  end

  always_comb begin
    dec    = '0;
    dec.rd = instr[11:7];
    wr     = 1'b0;
    ill    = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.d0 = rs1_data;
        dec.d1 = rs2_data;
        wr     = 1'b1;
        if (funct7 == 7'b0000000)                         dec.ctrl = op_fn;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.ctrl = 4'b0001;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.ctrl = 4'b0101;
        else                                              ill = 1'b1;
      end
      7'b0010011: begin
        dec.d0   = rs1_data;
        dec.d1   = imm_i;
        wr       = 1'b1;
        dec.ctrl = op_fn;
        // Shift-immediates reuse imm[11:5] as funct7; all other I-types take the full immediate.
        if (funct3 == 3'b001 && funct7 != 7'b0000000) ill = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)      dec.ctrl = 4'b0101;
          else if (funct7 != 7'b0000000) ill = 1'b1;
        end
      end
      7'b0000011: begin
        dec.d0 = rs1_data;
        dec.d1 = imm_i;
        wr     = 1'b1;
      end
      7'b0100011: begin
        dec.d0 = rs1_data;
        dec.d1 = imm_s;
      end
      7'b1100011: begin
        dec.d0  = rs1_data;
        dec.d1  = rs2_data;
        dec.br  = 1'b1;
        dec.tgt = pc + imm_b;
        case (funct3)
          3'b000:  dec.ctrl = 4'b1100;
          3'b001:  dec.ctrl = 4'b1101;
          3'b100:  dec.ctrl = 4'b1000;
          3'b101:  dec.ctrl = 4'b1001;
          3'b110:  dec.ctrl = 4'b1010;
          3'b111:  dec.ctrl = 4'b1011;
          default: ill = 1'b1;
        endcase
      end
      7'b0110111: begin
        dec.d1 = imm_u;
        wr     = 1'b1;
      end
      7'b0010111: begin
        dec.d0 = pc;
        dec.d1 = imm_u;
        wr     = 1'b1;
      end
      7'b1101111: begin
        dec.d0  = pc;
        dec.d1  = XLEN'(4);
        dec.tgt = pc + imm_j;
        wr      = 1'b1;
      end
      7'b1100111: begin
        dec.d0  = pc;
        dec.d1  = XLEN'(4);
        dec.tgt = (rs1_data + imm_i) & ~XLEN'(1);
        wr      = 1'b1;
        ill     = (funct3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase
    dec.rw = wr && (instr[11:7] != 5'd0);
    // Illegal entries still issue so execute can raise the exception, but with inert fields.
    if (ill) begin
      dec.ctrl = 4'b0000;
      dec.d0   = '0;
      dec.d1   = '0;
      dec.rw   = 1'b0;
      dec.br   = 1'b0;
      dec.tgt  = '0;
      dec.ill  = 1'b1;
    end
  end

  assign out_free = !out_valid_q || out_ready;

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_full_q, skid_full_d;
  assign in_ready = !skid_full_q;
`else
  assign in_ready = out_free;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    issue_cnt_d = issue_cnt_q;
`ifdef ALU_ISSUE_SKID_EN
    skid_full_d = skid_full_q;
    skid_d      = skid_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      skid_full_d = 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        issue_cnt_d = issue_cnt_q + XLEN'(1);
      end
`ifdef ALU_ISSUE_SKID_EN
      // The skid entry is older than anything on the input, so it always goes first.
      if (out_free) begin
        if (skid_full_q) begin
          out_valid_d = 1'b1;
          out_d       = skid_q;
          skid_full_d = 1'b0;
        end else if (in_valid) begin
          out_valid_d = 1'b1;
          out_d       = dec;
        end
      end else if (in_valid && !skid_full_q) begin
        skid_d      = dec;
        skid_full_d = 1'b1;
      end
`else
      if (in_valid && in_ready) begin
        out_valid_d = 1'b1;
        out_d       = dec;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      issue_cnt_q <= RESET_PC_CNT;
`ifdef ALU_ISSUE_SKID_EN
      skid_full_q <= 1'b0;
      skid_q      <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      issue_cnt_q <= issue_cnt_d;
`ifdef ALU_ISSUE_SKID_EN
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_ctrl      = out_q.ctrl;
  assign alu_data0     = out_q.d0;
  assign alu_data1     = out_q.d1;
  assign rd            = out_q.rd;
  assign reg_write     = out_q.rw;
  assign is_branch     = out_q.br;
  assign branch_target = out_q.tgt;
  assign illegal       = out_q.ill;
  assign issue_cnt     = issue_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal checks plus randomized traffic against a one-slot behavioural model.
module tb_alu_issue_stage;

  localparam logic [31:0] RST_CNT = 32'hFFFF_FFFF;
  // Register-register ALU codes indexed by funct3 (4 bits each, funct3=0 in the low nibble).
  localparam logic [31:0] RMAP = {4'd7, 4'd6, 4'd4, 4'd3, 4'd15, 4'd14, 4'd2, 4'd0};
  localparam logic [31:0] BMAP = {4'd11, 4'd10, 4'd9, 4'd8, 4'd0, 4'd0, 4'd13, 4'd12};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic        in_ready, out_valid, reg_write, is_branch, illegal;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic [31:0] alu_data0, alu_data1, branch_target, issue_cnt;

  int checks = 0;
  int errors = 0;
  logic run_cmp = 1'b0;

  alu_issue_stage #(.XLEN(32), .RESET_PC_CNT(RST_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .alu_data0(alu_data0), .alu_data1(alu_data1), .rd(rd), .reg_write(reg_write),
    .is_branch(is_branch), .branch_target(branch_target), .illegal(illegal), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic [31:0] tgt;
    logic        ill;
  } ent_t;

  logic        m_vld = 1'b0;
  logic [31:0] m_cnt = RST_CNT;
  ent_t        m_ent = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] p,
                                      input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    logic ok, writes;
    int f3;
    logic [6:0] f7;
    logic [31:0] ii, is, ib, iu, ij;
    f3 = int'(w[14:12]);
    f7 = w[31:25];
    ii = {{20{w[31]}}, w[31:20]};
    is = {{20{w[31]}}, w[31:25], w[11:7]};
    ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    iu = {w[31:12], 12'h000};
    ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    e = '0;
    ok = 1'b1;
    writes = 1'b0;
    case (w[6:0])
      7'b0110011: begin
        e.d0 = a; e.d1 = b; writes = 1'b1;
        if (f7 == 7'h00) e.ctrl = RMAP[f3*4 +: 4];
        else if (f7 == 7'h20 && f3 == 0) e.ctrl = 4'd1;
        else if (f7 == 7'h20 && f3 == 5) e.ctrl = 4'd5;
        else ok = 1'b0;
      end
      7'b0010011: begin
        e.d0 = a; e.d1 = ii; writes = 1'b1; e.ctrl = RMAP[f3*4 +: 4];
        if (f3 == 1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 5 && f7 == 7'h20) e.ctrl = 4'd5;
        if (f3 == 5 && f7 != 7'h20 && f7 != 7'h00) ok = 1'b0;
      end
      7'b0000011: begin e.d0 = a; e.d1 = ii; writes = 1'b1; end
      7'b0100011: begin e.d0 = a; e.d1 = is; end
      7'b1100011: begin
        e.d0 = a; e.d1 = b; e.br = 1'b1; e.tgt = p + ib; e.ctrl = BMAP[f3*4 +: 4];
        if (f3 == 2 || f3 == 3) ok = 1'b0;
      end
      7'b0110111: begin e.d1 = iu; writes = 1'b1; end
      7'b0010111: begin e.d0 = p; e.d1 = iu; writes = 1'b1; end
      7'b1101111: begin e.d0 = p; e.d1 = 32'd4; e.tgt = p + ij; writes = 1'b1; end
      7'b1100111: begin
        e.d0 = p; e.d1 = 32'd4; e.tgt = (a + ii) & 32'hFFFF_FFFE; writes = 1'b1;
        if (f3 != 0) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    e.rd = w[11:7];
    e.rw = ok && writes && (w[11:7] != 5'd0);
    return e;
  endfunction

  // One-slot model: a consumed slot frees first, then an offered input fills any free slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld = 1'b0;
      m_cnt = RST_CNT;
    end else if (flush) begin
      m_vld = 1'b0;
    end else begin
      if (m_vld && out_ready) begin
        m_cnt = m_cnt + 32'd1;
        m_vld = 1'b0;
      end
      if (in_valid && !m_vld) begin
        m_vld = 1'b1;
        m_ent = ref_decode(instr, pc, rs1_data, rs2_data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("issue_cnt", issue_cnt, m_cnt);
      chk("in_ready", 32'(in_ready), 32'(!m_vld || out_ready));
      if (m_vld) begin
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ent.ctrl));
        chk("alu_data0", alu_data0, m_ent.d0);
        chk("alu_data1", alu_data1, m_ent.d1);
        chk("rd", 32'(rd), 32'(m_ent.rd));
        chk("reg_write", 32'(reg_write), 32'(m_ent.rw));
        chk("is_branch", 32'(is_branch), 32'(m_ent.br));
        chk("branch_target", branch_target, m_ent.tgt);
        chk("illegal", 32'(illegal), 32'(m_ent.ill));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy, input logic fl);
    in_valid = v; instr = w; pc = p; rs1_data = a; rs2_data = b; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] op;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b0110111;
      6: op = 7'b0010111;
      7: op = 7'b1101111;
      8: op = 7'b1100111;
      default: op = w[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    if (k == 8 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
    w[6:0] = op;
    return w;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({tag, "_data0"}, alu_data0, 32'd0);
    chk({tag, "_data1"}, alu_data1, 32'd0);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    chk({tag, "_is_branch"}, 32'(is_branch), 32'd0);
    chk({tag, "_target"}, branch_target, 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_issue_cnt"}, issue_cnt, RST_CNT);
  endtask

  initial begin
    #22;
    chk_reset_state("rst");
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    run_cmp = 1'b1;
    #1;

    // SUB x3,x1,x2
    drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd3, 1'b1, 1'b0);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_ctrl", 32'(alu_ctrl), 32'b0001);
    chk("sub_d0", alu_data0, 32'd10);
    chk("sub_d1", alu_data1, 32'd3);
    chk("sub_rd", 32'(rd), 32'd3);
    chk("sub_rw", 32'(reg_write), 32'd1);
    chk("model_sub_ctrl", 32'(m_ent.ctrl), 32'b0001);
    chk("sub_cnt", issue_cnt, 32'hFFFF_FFFF);

    // BLTU x1,x2,-8 at pc 0x100; SUB issues this edge so the counter wraps to 0
    drive(1'b1, 32'hFE20ECE3, 32'h100, 32'd1, 32'd2, 1'b1, 1'b0);
    chk("bltu_ctrl", 32'(alu_ctrl), 32'b1010);
    chk("bltu_br", 32'(is_branch), 32'd1);
    chk("bltu_rw", 32'(reg_write), 32'd0);
    chk("bltu_tgt", branch_target, 32'h0000_00F8);
    chk("model_bltu_tgt", m_ent.tgt, 32'h0000_00F8);
    chk("wrap_cnt", issue_cnt, 32'd0);

    // SRAI x5,x5,4
    drive(1'b1, 32'h4042D293, 32'h104, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    chk("srai_ctrl", 32'(alu_ctrl), 32'b0101);
    chk("srai_d1", alu_data1, 32'h404);
    chk("srai_ill", 32'(illegal), 32'd0);
    chk("cnt_1", issue_cnt, 32'd1);

    // SLLI-shaped word with funct7 0x20 is illegal
    drive(1'b1, 32'h40429293, 32'h108, 32'h1234, 32'h5678, 1'b1, 1'b0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_ctrl", 32'(alu_ctrl), 32'd0);
    chk("ill_d0", alu_data0, 32'd0);
    chk("ill_d1", alu_data1, 32'd0);
    chk("ill_rw", 32'(reg_write), 32'd0);
    chk("model_ill", 32'(m_ent.ill), 32'd1);
    chk("cnt_2", issue_cnt, 32'd2);

    // Stall three cycles with a pending ADDI x1,x0,5
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00500093, 32'h10C, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold_ill", 32'(illegal), 32'd1);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_cnt", issue_cnt, 32'd2);
    end
    drive(1'b1, 32'h00500093, 32'h10C, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("rel_cnt_3", issue_cnt, 32'd3);
    chk("addi_d1", alu_data1, 32'd5);
    drive(1'b1, 32'h00500093, 32'h110, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("rel_cnt_4", issue_cnt, 32'd4);

    // Flush beats drain and load
    drive(1'b1, 32'h402081B3, 32'h114, 32'd7, 32'd9, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_cnt", issue_cnt, 32'd4);
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("post_flush_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    // Async reset in the middle of a stall
    drive(1'b1, 32'h402081B3, 32'h200, 32'd10, 32'd3, 1'b1, 1'b0);
    drive(1'b1, 32'h00500093, 32'h204, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h00500093, 32'h204, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
